// File: rtl/monitor_host_link_pkg.sv
// Shared constants and FSM state types for the host side of the board monitor link.
// Optional checksum trailer: define MONITOR_HOST_CHECKSUM_EN.
package monitor_host_link_pkg;

    localparam logic [7:0] CMD_HDR   = 8'h5A;
    localparam logic [7:0] STAT_HDR  = 8'hA5;
    localparam logic [6:0] HEX_BLANK = 7'h7F;

`ifdef MONITOR_HOST_CHECKSUM_EN
    localparam int unsigned CMD_LEN  = 4;
    localparam int unsigned STAT_LEN = 10;
`else
    localparam int unsigned CMD_LEN  = 3;
    localparam int unsigned STAT_LEN = 9;
`endif

    typedef enum logic [2:0] {TxIdle, TxLoad, TxStart, TxData, TxStop, TxNext} tx_state_e;
    typedef enum logic {RxHunt, RxPayload} rx_state_e;

    // Command frame byte by index; snap is {KEY[3:0], SW[9:0]}.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [13:0] snap);
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = snap[7:0];
        b2 = {snap[13:10], 2'b00, snap[9:8]};
        case (idx)
            2'd0:    cmd_byte = CMD_HDR;
            2'd1:    cmd_byte = b1;
            2'd2:    cmd_byte = b2;
`ifdef MONITOR_HOST_CHECKSUM_EN
            default: cmd_byte = CMD_HDR ^ b1 ^ b2;
`else
            default: cmd_byte = CMD_HDR;
`endif
        endcase
    endfunction

endpackage

// File: rtl/monitor_uart_rx_byte.sv
// 8N1 byte receiver: start-bit glitch rejection, mid-bit sampling, framing-error flag.
module monitor_uart_rx_byte #(
    parameter int unsigned Cpb = 5208
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(Cpb + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            rx_prev_q;

    assign busy_o = (state_q != StIdle);

    // Byte FSM; valid/frame_err are single-cycle registered pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_prev_q   <= 1'b1;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            rx_prev_q   <= rx_i;
            case (state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_i) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntW'(Cpb / 2 - 1)) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        // Line back high at mid-start means a glitch, not a start bit.
                        state_q <= rx_i ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntW'(Cpb - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_i, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= StStop;
                        else               bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntW'(Cpb - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (rx_i) begin
                            data_o  <= shift_q;
                            valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/monitor_host_link.sv
// Host end of the board monitor UART link: sends {KEY,SW} command frames and mirrors
// the board's LED/HEX status frames. Optional checksum: MONITOR_HOST_CHECKSUM_EN.
module monitor_host_link
    import monitor_host_link_pkg::*;
#(
    parameter int unsigned baud  = 9600,
    parameter int unsigned clock = 50000000
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_RX,
    input  logic [9:0] i_SWITCH,
    input  logic [3:0] i_BUTTON,
    output logic       o_TX,
    output logic [9:0] o_LEDS,
    output logic [6:0] o_7S5,
    output logic [6:0] o_7S4,
    output logic [6:0] o_7S3,
    output logic [6:0] o_7S2,
    output logic [6:0] o_7S1,
    output logic [6:0] o_7S0,
    output logic       o_FRAME_OK,
    output logic       o_TX_BUSY
);

    localparam int unsigned Cpb     = clock / baud;
    localparam int unsigned CntW    = $clog2(Cpb + 1);
    localparam int unsigned Timeout = 16 * Cpb;
    localparam int unsigned ToW     = $clog2(Timeout + 1);
    localparam int unsigned HexShN  = STAT_LEN - 4;

    // Synchronised inputs; SW/KEY reset to all-ones so they match last_sent until real
    // values arrive, which keeps a stale zero snapshot from being sent after reset.
    logic       rx_s1_q, rx_s2_q;
    logic [9:0] sw_s1_q, sw_s2_q;
    logic [3:0] key_s1_q, key_s2_q;

    // Two-flop synchronisers for all asynchronous inputs.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            sw_s1_q  <= '1;
            sw_s2_q  <= '1;
            key_s1_q <= '1;
            key_s2_q <= '1;
        end else begin
            rx_s1_q  <= i_RX;
            rx_s2_q  <= rx_s1_q;
            sw_s1_q  <= i_SWITCH;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= i_BUTTON;
            key_s2_q <= key_s1_q;
        end
    end

    tx_state_e       tx_state_q;
    logic [13:0]     last_sent_q;
    logic [7:0]      tx_shift_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [1:0]      tx_idx_q;

    // TX serialiser. LOAD is the first cycle of the start bit and NEXT the last cycle
    // of the stop bit, so every bit is exactly Cpb clocks with no inter-byte gap.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            tx_state_q  <= TxIdle;
            last_sent_q <= 14'h3FFF;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_idx_q    <= '0;
            o_TX        <= 1'b1;
            o_TX_BUSY   <= 1'b0;
        end else begin
            case (tx_state_q)
                TxIdle: begin
                    if ({key_s2_q, sw_s2_q} != last_sent_q) begin
                        last_sent_q <= {key_s2_q, sw_s2_q};
                        tx_idx_q    <= '0;
                        o_TX        <= 1'b0;
                        o_TX_BUSY   <= 1'b1;
                        tx_state_q  <= TxLoad;
                    end
                end
                TxLoad: begin
                    tx_shift_q <= cmd_byte(tx_idx_q, last_sent_q);
                    tx_cnt_q   <= CntW'(1);
                    tx_state_q <= TxStart;
                end
                TxStart: begin
                    if (tx_cnt_q == CntW'(Cpb - 1)) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        o_TX       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == CntW'(Cpb - 1)) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            o_TX       <= 1'b1;
                            tx_state_q <= TxStop;
                        end else begin
                            o_TX       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == CntW'(Cpb - 2)) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxNext;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxNext: begin
                    if (tx_idx_q == 2'(CMD_LEN - 1)) begin
                        o_TX_BUSY  <= 1'b0;
                        tx_state_q <= TxIdle;
                    end else begin
                        tx_idx_q   <= tx_idx_q + 1'b1;
                        tx_shift_q <= cmd_byte(tx_idx_q + 1'b1, last_sent_q);
                        o_TX       <= 1'b0;
                        tx_state_q <= TxStart;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    logic [7:0] byte_data;
    logic       byte_valid, byte_err, byte_busy;

    monitor_uart_rx_byte #(
        .Cpb(Cpb)
    ) u_rx_byte (
        .clk_i       (i_CLK),
        .rst_ni      (i_RST),
        .rx_i        (rx_s2_q),
        .data_o      (byte_data),
        .valid_o     (byte_valid),
        .frame_err_o (byte_err),
        .busy_o      (byte_busy)
    );

    rx_state_e      rx_state_q;
    logic [3:0]     rx_idx_q;
    logic [ToW-1:0] idle_cnt_q;
    logic [7:0]     led_lo_q;
    logic [1:0]     led_hi_q;
    logic [6:0]     hex_sh_q [0:HexShN-1];
    logic [2:0]     hex_wr;
    logic           commit_ok;
    logic [6:0]     last_hex;

    assign hex_wr = rx_idx_q[2:0] - 3'd2;

`ifdef MONITOR_HOST_CHECKSUM_EN
    logic [7:0] rx_csum_q;
    assign commit_ok = (byte_data == rx_csum_q);
    assign last_hex  = hex_sh_q[5];
`else
    assign commit_ok = 1'b1;
    assign last_hex  = byte_data[6:0];
`endif

    // RX frame FSM: collect payload into a shadow and publish it atomically.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            rx_state_q <= RxHunt;
            rx_idx_q   <= '0;
            idle_cnt_q <= '0;
            led_lo_q   <= '0;
            led_hi_q   <= '0;
            for (int i = 0; i < HexShN; i++) hex_sh_q[i] <= HEX_BLANK;
`ifdef MONITOR_HOST_CHECKSUM_EN
            rx_csum_q  <= '0;
`endif
            o_LEDS     <= '0;
            o_7S0      <= HEX_BLANK;
            o_7S1      <= HEX_BLANK;
            o_7S2      <= HEX_BLANK;
            o_7S3      <= HEX_BLANK;
            o_7S4      <= HEX_BLANK;
            o_7S5      <= HEX_BLANK;
            o_FRAME_OK <= 1'b0;
        end else begin
            o_FRAME_OK <= 1'b0;
            case (rx_state_q)
                RxHunt: begin
                    idle_cnt_q <= '0;
                    if (byte_valid && byte_data == STAT_HDR) begin
                        rx_idx_q   <= '0;
                        rx_state_q <= RxPayload;
`ifdef MONITOR_HOST_CHECKSUM_EN
                        rx_csum_q  <= byte_data;
`endif
                    end
                end
                RxPayload: begin
                    if (byte_err) begin
                        rx_state_q <= RxHunt;
                    end else if (byte_valid) begin
                        idle_cnt_q <= '0;
`ifdef MONITOR_HOST_CHECKSUM_EN
                        rx_csum_q  <= rx_csum_q ^ byte_data;
`endif
                        if (rx_idx_q == 4'(STAT_LEN - 2)) begin
                            rx_state_q <= RxHunt;
                            if (commit_ok) begin
                                o_LEDS     <= {led_hi_q, led_lo_q};
                                o_7S0      <= hex_sh_q[0];
                                o_7S1      <= hex_sh_q[1];
                                o_7S2      <= hex_sh_q[2];
                                o_7S3      <= hex_sh_q[3];
                                o_7S4      <= hex_sh_q[4];
                                o_7S5      <= last_hex;
                                o_FRAME_OK <= 1'b1;
                            end
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                            if (rx_idx_q == 4'd0)      led_lo_q         <= byte_data;
                            else if (rx_idx_q == 4'd1) led_hi_q         <= byte_data[1:0];
                            else                       hex_sh_q[hex_wr] <= byte_data[6:0];
                        end
                    end else if (byte_busy) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == ToW'(Timeout)) begin
                        rx_state_q <= RxHunt;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_host_link.sv
// Directed bench for monitor_host_link at a shortened bit period (CPB = 16).
module tb_monitor_host_link;

    localparam int CPB = 16;
`ifdef MONITOR_HOST_CHECKSUM_EN
    localparam int CMD_N = 4;
`else
    localparam int CMD_N = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [9:0] sw = 10'h2A5;
    logic [3:0] key = 4'hA;
    logic       tx, frame_ok, tx_busy;
    logic [9:0] leds;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

    int n_vec = 0;
    int n_err = 0;
    int ok_count = 0;
    int busy_cycles = 0;
    logic [7:0] frm [0:8];
    bit corrupt_csum = 1'b0;

    always #5 clk = ~clk;

    monitor_host_link #(
        .baud  (20000),
        .clock (320000)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst_n),
        .i_RX       (rx),
        .i_SWITCH   (sw),
        .i_BUTTON   (key),
        .o_TX       (tx),
        .o_LEDS     (leds),
        .o_7S5      (hex5),
        .o_7S4      (hex4),
        .o_7S3      (hex3),
        .o_7S2      (hex2),
        .o_7S1      (hex1),
        .o_7S0      (hex0),
        .o_FRAME_OK (frame_ok),
        .o_TX_BUSY  (tx_busy)
    );

    always @(negedge clk) begin
        if (frame_ok === 1'b1) ok_count <= ok_count + 1;
        if (tx_busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
        frm[0] = b0; frm[1] = b1; frm[2] = b2; frm[3] = b3; frm[4] = b4;
        frm[5] = b5; frm[6] = b6; frm[7] = b7; frm[8] = b8;
    endtask

    function automatic logic [7:0] frame_csum();
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 9; i++) c = c ^ frm[i];
        return c;
    endfunction

    // Sends frm[first..8] (plus trailer if enabled); bad stop on bad_idx, idle gap after gap_idx.
    task automatic send_stat(input int first, input int bad_idx, input int gap_idx, input int gap_len);
        for (int i = first; i < 9; i++) begin
            send_byte(frm[i], (i == bad_idx) ? 1'b0 : 1'b1);
            if (i == bad_idx) repeat (2 * CPB) @(negedge clk);
            if (i == gap_idx) repeat (gap_len) @(negedge clk);
        end
`ifdef MONITOR_HOST_CHECKSUM_EN
        send_byte(corrupt_csum ? ~frame_csum() : frame_csum(), 1'b1);
`endif
        repeat (4) @(negedge clk);
    endtask

    // Decodes one command byte off o_TX, optionally changing SW once its start bit is seen.
    task automatic recv_cmd(output logic [7:0] b, input bit chg, input logic [9:0] sw_new);
        int n;
        n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < 40 * CPB) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            check("tx_start_seen", {31'b0, tx}, 32'h0);
            return;
        end
        if (chg) sw = sw_new;
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", {31'b0, tx}, 32'h1);
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input bit chg, input logic [9:0] sw_new);
        logic [7:0] b;
        recv_cmd(b, 1'b0, 10'h0);
        check({tag, "_b0"}, {24'b0, b}, {24'b0, 8'h5A});
        recv_cmd(b, 1'b0, 10'h0);
        check({tag, "_b1"}, {24'b0, b}, {24'b0, e1});
        recv_cmd(b, chg, sw_new);
        check({tag, "_b2"}, {24'b0, b}, {24'b0, e2});
`ifdef MONITOR_HOST_CHECKSUM_EN
        recv_cmd(b, 1'b0, 10'h0);
        check({tag, "_b3"}, {24'b0, b}, {24'b0, 8'h5A ^ e1 ^ e2});
`endif
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check("tx_busy_drop", {31'b0, tx_busy}, 32'h0);
    endtask

    task automatic check_outs(input string tag, input logic [9:0] l, input logic [6:0] h0,
                              input logic [6:0] h5, input int ok_exp);
        check({tag, "_leds"}, {22'b0, leds}, {22'b0, l});
        check({tag, "_hex0"}, {25'b0, hex0}, {25'b0, h0});
        check({tag, "_hex5"}, {25'b0, hex5}, {25'b0, h5});
        check({tag, "_ok"}, ok_count, ok_exp);
    endtask

    initial begin
        int bc0;
        int ok0;
        int n;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_busy", {31'b0, tx_busy}, 32'h0);
        check("rst_ok", {31'b0, frame_ok}, 32'h0);
        check("rst_leds", {22'b0, leds}, 32'h0);
        check("rst_hex0", {25'b0, hex0}, 32'h7F);
        check("rst_hex5", {25'b0, hex5}, 32'h7F);

        // First command frame after reset: SW=2A5, KEY=A
        bc0 = busy_cycles;
        rst_n = 1'b1;
        check_cmd("cmd1", 8'hA5, 8'hA2, 1'b0, 10'h0);
        wait_tx_idle();
        check("cmd1_busy_len", busy_cycles - bc0, CMD_N * 10 * CPB);

        // SW change during byte 2: frame completes unchanged, then a new frame follows
        sw = 10'h155;
        check_cmd("cmd2", 8'h55, 8'hA1, 1'b1, 10'h0F0);
        check_cmd("cmd3", 8'hF0, 8'hA0, 1'b0, 10'h0);
        wait_tx_idle();

        // Status frame; outputs stay put until the last byte lands
        ok0 = ok_count;
        set_frame(8'hA5, 8'h3C, 8'h02, 8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12);
        for (int i = 0; i < 8; i++) send_byte(frm[i], 1'b1);
        repeat (4) @(negedge clk);
        check("st1_atomic_leds", {22'b0, leds}, 32'h0);
        check("st1_atomic_ok", ok_count, ok0);
        send_stat(8, -1, -1, 0);
        check_outs("st1", 10'h23C, 7'h40, 7'h12, ok0 + 1);
        check("st1_hex1", {25'b0, hex1}, 32'h79);
        check("st1_hex2", {25'b0, hex2}, 32'h24);
        check("st1_hex3", {25'b0, hex3}, 32'h30);
        check("st1_hex4", {25'b0, hex4}, 32'h19);

        // Garbage ahead of the header
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        set_frame(8'hA5, 8'h55, 8'h01, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D);
        send_stat(0, -1, -1, 0);
        check_outs("st2", 10'h155, 7'h3F, 7'h6D, ok0 + 2);

        // Framing error on frame byte 4; the rest of that frame is ignored
        set_frame(8'hA5, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        send_stat(0, 4, -1, 0);
        check_outs("st3_ferr", 10'h155, 7'h3F, 7'h6D, ok0 + 2);
        set_frame(8'hA5, 8'h3C, 8'h02, 8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12);
        send_stat(0, -1, -1, 0);
        check_outs("st4_after_ferr", 10'h23C, 7'h40, 7'h12, ok0 + 3);

        // Inter-byte gap beyond 16 bit times drops the frame; one under it does not
        set_frame(8'hA5, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        send_stat(0, -1, 1, 20 * CPB);
        check_outs("st5_timeout", 10'h23C, 7'h40, 7'h12, ok0 + 3);
        set_frame(8'hA5, 8'h55, 8'h01, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D);
        send_stat(0, -1, 1, 14 * CPB);
        check_outs("st6_short_gap", 10'h155, 7'h3F, 7'h6D, ok0 + 4);

        // 0xA5 inside the payload is plain data; reserved bits ignored
        set_frame(8'hA5, 8'hA5, 8'hFC, 8'hC0, 8'h40, 8'h40, 8'h40, 8'h40, 8'hC0);
        send_stat(0, -1, -1, 0);
        check_outs("st7_a5_data", 10'h0A5, 7'h40, 7'h40, ok0 + 5);

`ifdef MONITOR_HOST_CHECKSUM_EN
        set_frame(8'hA5, 8'h01, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        corrupt_csum = 1'b1;
        send_stat(0, -1, -1, 0);
        check_outs("cs_bad", 10'h0A5, 7'h40, 7'h40, ok0 + 5);
        corrupt_csum = 1'b0;
        send_stat(0, -1, -1, 0);
        check_outs("cs_good", 10'h001, 7'h7F, 7'h7F, ok0 + 6);
`endif

        // Reset in the middle of both a command frame and a status frame
        sw = 10'h000;
        n = 0;
        while (tx_busy !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("mid_busy_rise", {31'b0, tx_busy}, 32'h1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check("mid_tx_low", {31'b0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'b0, tx}, 32'h1);
        check("mid_rst_busy", {31'b0, tx_busy}, 32'h0);
        check("mid_rst_leds", {22'b0, leds}, 32'h0);
        check("mid_rst_hex5", {25'b0, hex5}, 32'h7F);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/monitor_host_link.md
Name: monitor_host_link

Overview:
- Host-side counterpart of the board monitor UART link: drives a remote board's switches/buttons and mirrors its LEDs and 7-segment displays.
- Serialises local SW/KEY state into a command frame on o_TX.
- Deserialises the status frame arriving on i_RX into LED/HEX outputs.
- Sits in a second FPGA, or in a loopback harness facing the monitor, at the same baud and clock.

Parameters:
- baud, 9600, UART bit rate.
- clock, 50000000, i_CLK frequency in Hz. Bit period CPB = clock/baud, integer-truncated (5208).

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  asynchronous active-low reset
- i_RX  in  1  serial status stream from the board (idle high)
- i_SWITCH  in  10  switch state to send
- i_BUTTON  in  4  button state to send
- o_TX  out  1  serial command stream to the board (idle high)
- o_LEDS  out  10  mirrored LED state
- o_7S5..o_7S0  out  7 each  mirrored segment patterns (active-low)
- o_FRAME_OK  out  1  one-cycle pulse when a status frame is accepted
- o_TX_BUSY  out  1  high while a command frame is being shifted out

Behaviour:
- UART format: 8N1, LSB first.
- Reset values (asserted asynchronously, held while i_RST=0):
  - o_TX=1, o_LEDS=0, o_7S*=7'h7F.
  - o_FRAME_OK=0, o_TX_BUSY=0.
  - All FSMs in IDLE/HUNT; last-sent register = 14'h3FFF, which forces a first send.
- i_RX, i_SWITCH and i_BUTTON each pass through a 2-FF synchroniser before use.
- Command frame, 3 bytes: 0x5A, SW[7:0], {KEY[3:0],2'b00,SW[9:8]}.
- TX FSM states: IDLE, LOAD, START, DATA, STOP, NEXT.
  - IDLE: if synchronised {KEY,SW} != last-sent, latch a snapshot into last-sent and go to LOAD.
  - Snapshot is frozen for the whole frame; input changes mid-frame queue a new frame after completion.
  - Each bit lasts exactly CPB clocks; stop bit is 1 bit.
  - No idle gap between bytes; NEXT advances the byte index, and after the last byte goes to IDLE.
  - o_TX_BUSY is high from LOAD through the end of the final stop bit.
- Status frame, 9 bytes: 0xA5, LED[7:0], {6'b0,LED[9:8]}, {1'b0,HEX0}..{1'b0,HEX5}.
- RX byte receiver:
  - Falling edge of synchronised RX arms start; re-check at CPB/2 and return to idle if high (glitch).
  - Sample data bits at CPB intervals from the start mid-point.
  - Stop bit sampled low = framing error: discard the byte and signal error.
- RX frame FSM states: HUNT, PAYLOAD.
  - HUNT: ignore any byte other than 0xA5.
  - PAYLOAD: store bytes into a shadow register by index 0..7.
  - Framing error in PAYLOAD → HUNT; shadow discarded and outputs unchanged.
  - No special meaning of 0xA5 inside the payload; it is data.
  - After byte 7: copy shadow to o_LEDS/o_7S* in one cycle (atomic update), pulse o_FRAME_OK the same cycle, return to HUNT.
  - Reserved bits (byte2[7:2], HEX byte bit7) are ignored.
- Inter-byte timeout: more than 16×CPB idle in PAYLOAD → HUNT.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame: TX line returns high immediately and the partial frame is abandoned; the RX partial frame is discarded.

Optional Feature:
- Macro: MONITOR_HOST_CHECKSUM_EN.
- Defined:
  - Each frame carries an extra trailing byte equal to the XOR of all preceding bytes, including the header.
  - TX appends it (4-byte frame).
  - RX expects 10 bytes; on mismatch it discards the frame (no output update, no o_FRAME_OK) and goes to HUNT.
- Undefined: frames are exactly as above with no checksum logic present.

Decomposition:
- Shared package holds:
  - Header constants: CMD_HDR=8'h5A, STAT_HDR=8'hA5.
  - Frame length constants (3/9, and 4/10 with checksum).
  - State enums for TX and RX frame FSMs.
  - Reset pattern HEX_BLANK=7'h7F.
- One sub-module: monitor_uart_rx_byte, a byte receiver with data/valid/frame-error outputs, parameterised by CPB.
- The TX serialiser stays inline.

Test Plan:
- Reset release with SW=10'h2A5, KEY=4'hA:
  - Bytes sent: 0x5A, 0xA5, 0xA2.
  - Each bit 5208 clocks; o_TX_BUSY high for 30×5208 clocks.
- Status frame A5 3C 02 40 79 24 30 19 12 sent at 9600 baud:
  - o_LEDS=10'h23C; o_7S0=7'h40..o_7S5=7'h12.
  - One o_FRAME_OK pulse after the last stop bit.
- Garbage 0x00 0xFF before the header, then a valid frame: outputs update exactly once.
- Stop bit forced low on payload byte 4:
  - Outputs keep their prior values; no pulse.
  - A following valid frame is accepted.
- SW changes during byte 2 of a command frame: current frame completes unchanged, then a second frame carries the new SW.
- With MONITOR_HOST_CHECKSUM_EN, frame A5 01 00 7F×6 with a wrong checksum: no update. With checksum 0xA4: accepted.
